fifo_reader: RTL

Read-side front end for the team's synchronous FIFO. It pops words through the FIFO's registered read port (data valid one cycle after the read strobe) and presents them downstream as a first-word-fall-through valid/ready stream. A small internal prefetch buffer lets the sink stall without losing words that are already in flight. It sits between the fifo block and any consumer (serializer, checker, output port).

---
 rtl/fifo_reader_pkg.sv | 10 +
 rtl/fifo_reader_buf.sv | 39 +++
 rtl/fifo_reader.sv | 50 +++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared defaults, pointer-width helper and word type for fifo_reader.
package fifo_reader_pkg;
    localparam int DATA_W_D    = 8;
    localparam int BUF_DEPTH_D = 3;
    localparam int CNT_W_D     = 16;
    typedef logic [DATA_W_D-1:0] word_t;
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: circular prefetch storage with wrapping write/read pointers and occupancy.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int DEPTH = BUF_DEPTH_D,
    localparam int PW = ptr_w(DEPTH),
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic [OW-1:0]     occ
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= wr_data;
                wptr      <= inc(wptr);
            end
            if (rd) rptr <= inc(rptr);
            occ <= occ + OW'(wr) - OW'(rd);
        end
    end
    assign rd_data = mem[rptr];
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: FWFT valid/ready front end for the registered-read FIFO, with prefetch buffer.
// Optional handshake counter xfer_cnt is built when FIFO_RD_CNT_EN is defined.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int BUF_DEPTH = BUF_DEPTH_D
`ifdef FIFO_RD_CNT_EN
    , parameter int CNT_W = CNT_W_D
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    , output logic [CNT_W-1:0] xfer_cnt
`endif
);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    logic inflight, pop;
    logic [OW-1:0] occ;
    // Reserve a slot for every word in flight so the buffer can never overflow.
    assign fifo_rd_en = rst_n && !fifo_empty && (int'(occ) + int'(inflight)) < BUF_DEPTH;
    assign m_valid = occ != '0;
    assign pop = m_valid && m_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else inflight <= fifo_rd_en;
    end
    fifo_reader_buf #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_buf (
        .clk(clk),
        .rst_n(rst_n),
        .wr(inflight),
        .wr_data(fifo_rd_data),
        .rd(pop),
        .rd_data(m_data),
        .occ(occ)
    );
`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt <= '0;
        else xfer_cnt <= pop ? xfer_cnt + 1'b1 : xfer_cnt;
    end
`endif
endmodule
